// File: rtl/codificador_pkg.sv
// Shared types and constants for the Codificador sequencer and its display scanner.
// Imported by controlador_codificador and varredura_display.
package codificador_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CAPTURE,
        FINISH
    } state_t;

    localparam int   DATA_W_DEFAULT    = 4;
    localparam logic ENC_RESET_RST     = 1'b1;
    localparam int   DIGIT_SEL_RST_IDX = 0;

endpackage

// File: rtl/varredura_display.sv
// Free-running digit scanner: holds each digit for SCAN_DIV cycles, then rotates the
// one-hot select and muxes the matching display-buffer entry onto the shared decoder.
module varredura_display
    import codificador_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_DIGITS*DATA_W-1:0] i_displayBuf,
    output logic [DATA_W-1:0]            o_segCode,
    output logic [NUM_DIGITS-1:0]        o_digitSel
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] r_scanCnt;
    logic [IDX_W-1:0] r_scanIdx;

    // With SCAN_DIV=1 the counter is pinned at its last value, so the digit advances every cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scanCnt <= '0;
            r_scanIdx <= IDX_W'(DIGIT_SEL_RST_IDX);
        end else if (r_scanCnt == CNT_LAST) begin
            r_scanCnt <= '0;
            r_scanIdx <= (r_scanIdx == IDX_LAST) ? '0 : r_scanIdx + IDX_W'(1);
        end else begin
            r_scanCnt <= r_scanCnt + CNT_W'(1);
        end
    end

    always_comb begin
        o_digitSel = NUM_DIGITS'(1) << r_scanIdx;
        o_segCode  = i_displayBuf[int'(r_scanIdx)*DATA_W +: DATA_W];
    end

endmodule

// File: rtl/controlador_codificador.sv
// Batch sequencer for the Codificador: encodes NUM_DIGITS codes one at a time into a
// shadow buffer, commits them atomically to the display buffer and drives the scanner.
module controlador_codificador
    import codificador_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_load,
    input  logic [NUM_DIGITS*DATA_W-1:0] i_loadData,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [DATA_W-1:0]            o_encInput,
    output logic                         o_encReady,
    output logic                         o_encReset,
    input  logic [DATA_W-1:0]            i_encOutput,
    output logic [DATA_W-1:0]            o_segCode,
    output logic [NUM_DIGITS-1:0]        o_digitSel
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    state_t                       r_state;
    logic [IDX_W-1:0]             r_index;
    logic [NUM_DIGITS*DATA_W-1:0] r_inputBuf;
    logic [NUM_DIGITS*DATA_W-1:0] r_shadow;
    logic [NUM_DIGITS*DATA_W-1:0] r_display;
    logic                         r_busy;
    logic                         r_done;
    logic [DATA_W-1:0]            r_encInput;
    logic                         r_encReady;
    logic                         r_encReset;

    // Outputs are registered alongside the state they belong to, so each transition
    // sets the drive values for the state being entered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_index    <= '0;
            r_inputBuf <= '0;
            r_shadow   <= '0;
            r_display  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_encInput <= '0;
            r_encReady <= 1'b0;
            r_encReset <= ENC_RESET_RST;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_load) begin
                        r_inputBuf <= i_loadData;
                        r_index    <= '0;
                        r_state    <= DRIVE;
                        r_busy     <= 1'b1;
                        r_encInput <= i_loadData[0 +: DATA_W];
                        r_encReady <= 1'b1;
                        r_encReset <= 1'b0;
                    end
                end
                DRIVE: begin
                    r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_shadow[int'(r_index)*DATA_W +: DATA_W] <= i_encOutput;
                    if (r_index == IDX_LAST) begin
                        r_state    <= FINISH;
                        r_done     <= 1'b1;
                        r_encInput <= '0;
                        r_encReady <= 1'b0;
                        r_encReset <= 1'b1;
                    end else begin
                        r_index    <= r_index + IDX_W'(1);
                        r_state    <= DRIVE;
                        r_encInput <= r_inputBuf[(int'(r_index) + 1)*DATA_W +: DATA_W];
                    end
                end
                FINISH: begin
                    r_display <= r_shadow;
                    r_state   <= IDLE;
                    r_done    <= 1'b0;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_encInput = r_encInput;
    assign o_encReady = r_encReady;
    assign o_encReset = r_encReset;

    varredura_display #(
        .NUM_DIGITS (NUM_DIGITS),
        .DATA_W     (DATA_W),
        .SCAN_DIV   (SCAN_DIV)
    ) u_varredura (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_displayBuf (r_display),
        .o_segCode    (o_segCode),
        .o_digitSel   (o_digitSel)
    );

endmodule

// File: tb/tb_controlador_codificador.sv
// Directed bench for controlador_codificador with a behavioural Codificador model;
// a second instance with SCAN_DIV=1 exercises the every-cycle digit rotation.
module tb_controlador_codificador;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] loadData;

    logic        busy, done, encReady, encReset;
    logic [3:0]  encInput, encOutput, segCode;
    logic [3:0]  digitSel;

    logic        busy1, done1, encReady1, encReset1;
    logic [3:0]  encInput1, segCode1, digitSel1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int doneCount;
    logic [3:0] expDisp [4];

    always #5 clk = ~clk;

    // Stand-in encoder: rotate left by one and invert alternate bits.
    function automatic logic [3:0] enc(input logic [3:0] x);
        return {x[2:0], x[3]} ^ 4'hA;
    endfunction

    assign encOutput = encReady ? enc(encInput) : 4'h0;

    // Edges since reset release; drives the expected scan position.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    controlador_codificador #(.NUM_DIGITS(4), .DATA_W(4), .SCAN_DIV(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_load      (load),
        .i_loadData  (loadData),
        .o_busy      (busy),
        .o_done      (done),
        .o_encInput  (encInput),
        .o_encReady  (encReady),
        .o_encReset  (encReset),
        .i_encOutput (encOutput),
        .o_segCode   (segCode),
        .o_digitSel  (digitSel)
    );

    controlador_codificador #(.NUM_DIGITS(4), .DATA_W(4), .SCAN_DIV(1)) dut1 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_load      (1'b0),
        .i_loadData  (16'h0000),
        .o_busy      (busy1),
        .o_done      (done1),
        .o_encInput  (encInput1),
        .o_encReady  (encReady1),
        .o_encReset  (encReset1),
        .i_encOutput (4'h0),
        .o_segCode   (segCode1),
        .o_digitSel  (digitSel1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic l, input logic [15:0] d);
        load     = l;
        loadData = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setDisp(input logic [15:0] d);
        for (int i = 0; i < 4; i++) expDisp[i] = enc(d[i*4 +: 4]);
    endtask

    task automatic checkScan(input string tag);
        int idx;
        idx = (cyc / 4) % 4;
        checkOutput({tag, "_sel"}, 32'(digitSel), 32'(1 << idx));
        checkOutput({tag, "_seg"}, 32'(segCode), 32'(expDisp[idx]));
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"},     32'(busy),     32'(0));
        checkOutput({tag, "_done"},     32'(done),     32'(0));
        checkOutput({tag, "_encInput"}, 32'(encInput), 32'(0));
        checkOutput({tag, "_encReady"}, 32'(encReady), 32'(0));
        checkOutput({tag, "_encReset"}, 32'(encReset), 32'(1));
    endtask

    // Runs one batch from the Load edge through the commit; glitch injects a Load at T0+3.
    task automatic runBatch(input string tag, input logic [15:0] d, input bit glitch);
        applyStimulus(1'b1, d);
        tick();
        applyStimulus(1'b0, 16'h0000);
        for (int s = 0; s < 8; s++) begin
            checkOutput({tag, "_encInput"}, 32'(encInput), 32'(d[(s/2)*4 +: 4]));
            checkOutput({tag, "_encReady"}, 32'(encReady), 32'(1));
            checkOutput({tag, "_encReset"}, 32'(encReset), 32'(0));
            checkOutput({tag, "_busy"},     32'(busy),     32'(1));
            checkOutput({tag, "_done"},     32'(done),     32'(0));
            if (glitch && s == 2) applyStimulus(1'b1, 16'hFFFF);
            else                  applyStimulus(1'b0, 16'h0000);
            tick();
        end
        checkOutput({tag, "_doneT8"},     32'(done),     32'(1));
        checkOutput({tag, "_busyT8"},     32'(busy),     32'(1));
        checkOutput({tag, "_encReadyT8"}, 32'(encReady), 32'(0));
        checkOutput({tag, "_encResetT8"}, 32'(encReset), 32'(1));
        checkOutput({tag, "_encInputT8"}, 32'(encInput), 32'(0));
        checkScan({tag, "_preCommit"});
        tick();
        setDisp(d);
        checkIdleOutputs({tag, "_T9"});
        checkScan({tag, "_postCommit"});
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0000);
        setDisp(16'h0000);
        for (int i = 0; i < 4; i++) expDisp[i] = 4'h0;
        tick();
        tick();
        checkIdleOutputs("reset");
        checkOutput("reset_seg", 32'(segCode),  32'(0));
        checkOutput("reset_sel", 32'(digitSel), 32'(1));
        rst = 1'b0;

        runBatch("basic", 16'h3210, 1'b0);

        for (int i = 0; i < 16; i++) begin
            tick();
            checkScan("scan");
        end

        runBatch("loadBusy", 16'h3210, 1'b1);
        tick();
        checkOutput("loadBusy_noRestart", 32'(busy), 32'(0));

        // Back-to-back: Load held high; second batch must start at T0+10.
        doneCount = 0;
        applyStimulus(1'b1, 16'h2301);
        tick();
        for (int e = 0; e < 20; e++) begin
            if (done) doneCount++;
            if (e == 8) checkScan("b2b_preCommit");
            if (e == 9) begin
                checkOutput("b2b_busyT9", 32'(busy), 32'(0));
                setDisp(16'h2301);
                checkScan("b2b_postCommit");
            end
            if (e == 10) begin
                checkOutput("b2b_busyT10",     32'(busy),     32'(1));
                checkOutput("b2b_encInputT10", 32'(encInput), 32'(1));
            end
            if (e == 19) begin
                checkOutput("b2b_busyT19", 32'(busy), 32'(0));
                applyStimulus(1'b0, 16'h0000);
            end
            if (e < 19) tick();
        end
        checkOutput("b2b_doneCount", 32'(doneCount), 32'(2));
        for (int i = 0; i < 8; i++) begin
            tick();
            checkScan("b2b_scan");
        end

        // Reset during CAPTURE of digit 2.
        applyStimulus(1'b1, 16'h1111);
        tick();
        applyStimulus(1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("midReset_busyBefore", 32'(busy), 32'(1));
        rst = 1'b1;
        #1;
        checkIdleOutputs("midReset");
        checkOutput("midReset_sel", 32'(digitSel), 32'(1));
        checkOutput("midReset_seg", 32'(segCode),  32'(0));
        for (int i = 0; i < 4; i++) expDisp[i] = 4'h0;
        tick();
        rst = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) doneCount++;
            checkScan("afterReset");
        end
        checkOutput("afterReset_doneCount", 32'(doneCount), 32'(0));
        checkOutput("afterReset_busy",      32'(busy),      32'(0));

        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("div1_sel", 32'(digitSel1), 32'(1 << (cyc % 4)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/controlador_codificador.md
# controlador_codificador

Sequencer sitting in front of the Codificador/Display pair. It accepts a batch of four 4-bit codes, feeds them one by one through the combinational Codificador with the Ready handshake, and collects the encoded results in a shadow buffer. It then commits the batch atomically to a display buffer, which it time-multiplexes onto the single Display decoder with a one-hot digit select for a multi-digit 7-segment panel.

## Interface
Parameters:
- NUM_DIGITS, 4, number of codes per batch and display digits (≥1)
- DATA_W, 4, width of one code; must match Codificador Input/Output
- SCAN_DIV, 1000, clock cycles each digit stays selected (≥1)

Ports (one clock; reset is asynchronous and active-high):
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Load  in  1  request to encode a new batch; sampled only in IDLE
- LoadData  in  NUM_DIGITS*DATA_W  batch; digit i = bits [i*DATA_W +: DATA_W]
- Busy  out  1  high whenever state ≠ IDLE
- Done  out  1  one-cycle pulse when a batch is committed
- EncInput  out  DATA_W  drives Codificador Input
- EncReady  out  1  drives Codificador Ready
- EncReset  out  1  drives Codificador Reset
- EncOutput  in  DATA_W  from Codificador Output
- SegCode  out  DATA_W  drives the Display input (Output port of Display)
- DigitSel  out  NUM_DIGITS  one-hot active-high digit enable

## Operation
- States: IDLE, DRIVE, CAPTURE, FINISH.
- IDLE:
  - On Load=1 at an edge: latch LoadData into an input register, clear the digit index, go to DRIVE.
  - Load=0: stay in IDLE.
- DRIVE:
  - EncInput = code[index], EncReady=1, EncReset=0.
  - Next state: CAPTURE. This cycle is the settle time for the combinational encoder.
- CAPTURE:
  - Same drive values as DRIVE.
  - At the edge: shadow[index] ← EncOutput.
  - If index = NUM_DIGITS-1, go to FINISH; else increment index and go to DRIVE.
- FINISH:
  - Done=1, EncReady=0, EncReset=1.
  - At the edge: display buffer ← shadow (all digits at once), then go to IDLE.
- Outside DRIVE/CAPTURE: EncInput=0, EncReady=0, EncReset=1.
- Load during Busy is ignored and is not queued.
- Display scan runs in every state, independent of the FSM:
  - Counter counts 0..SCAN_DIV-1.
  - On wrap, scan index = (scan index+1) mod NUM_DIGITS.
  - DigitSel = 1 << scan index.
  - SegCode = display buffer[scan index].
  - A commit takes effect on the very next cycle's SegCode.
- Reset (asynchronous, any state, including mid-batch):
  - FSM → IDLE; shadow, display and input registers cleared to 0; partial batch discarded.
  - Scan counter and scan index → 0.
  - Output reset values: Busy=0, Done=0, EncInput=0, EncReady=0, EncReset=1, SegCode=0, DigitSel=…0001.

## Timing
- Load is sampled at edge T0. DRIVE for digit i spans cycles T0+2i to T0+2i+1, and CAPTURE spans cycles T0+2i+1 to T0+2i+2.
- Done is high exactly one cycle, from edge T0+2·NUM_DIGITS to T0+2·NUM_DIGITS+1. This is edge 8 for NUM_DIGITS=4.
- The display buffer updates at edge T0+2·NUM_DIGITS+1.
- Busy rises after T0 and falls at the same edge as Done.
- A new Load is accepted at the first edge at which the FSM is in IDLE, i.e. T0+2·NUM_DIGITS+2 at the earliest.
- Scan counter width = max(1, $clog2(SCAN_DIV)). With SCAN_DIV=1 the digit advances every cycle. Scan index wraps NUM_DIGITS-1 → 0.
- All outputs are decoded from registered state only; there is no combinational path from inputs to outputs.

## Structure
- Shared package `codificador_pkg`:
  - state enum (IDLE, DRIVE, CAPTURE, FINISH)
  - DATA_W default constant
  - reset value constants for EncReset and DigitSel
- Sub-module `varredura_display`: the scan counter, scan index, one-hot DigitSel and SegCode mux; parameterised on NUM_DIGITS, DATA_W and SCAN_DIV. The FSM and buffers stay in the top module.

## Test plan
- Reset mid-batch:
  - Stimulus: assert Reset during CAPTURE of digit 2.
  - Required: Busy=0, Done=0, EncReset=1, DigitSel=0001, SegCode=0 immediately; no Done afterwards.
- Basic batch:
  - Stimulus: SCAN_DIV=4, Load with LoadData=16'h3210, Codificador connected.
  - Required: EncInput sequence 0,0,1,1,2,2,3,3; Done exactly one cycle at edge T0+8; display buffer = encoded {3,2,1,0} at edge T0+9.
- Load while Busy:
  - Stimulus: second Load=1 with LoadData=16'hFFFF at T0+3.
  - Required: ignored; results identical to the basic batch.
- Back-to-back batches:
  - Stimulus: Load held high continuously.
  - Required: second batch starts at T0+10; exactly one Done per batch.
- Scan rotation:
  - Stimulus: SCAN_DIV=4, display buffer holding a known pattern.
  - Required: DigitSel steps 0001→0010→0100→1000→0001 every 4 cycles; SegCode matches the buffer entry for each digit; the committed batch appears atomically, with no digit mixing old and new values.
- SCAN_DIV=1:
  - Stimulus: SCAN_DIV=1.
  - Required: DigitSel rotates every cycle.
